// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, branch redirects,
// and a RUN/MEM_WAIT/TIMEOUT memory-wait FSM. Optional macro HAZARD_PERF_COUNTERS_EN adds counters.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT   = 64,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [4:0]               ID_RegisterRS_IN,
  input  logic [4:0]               ID_RegisterRT_IN,
  input  logic                     ID_UsesRS_IN,
  input  logic                     ID_UsesRT_IN,
  input  logic                     IDEXE_MemRead_IN,
  input  logic [4:0]               IDEXE_WriteRegister_IN,
  input  logic                     BranchTaken_IN,
  input  logic                     MemRequest_IN,
  input  logic                     MemReady_IN,
  output logic                     PC_STALL_OUT,
  output logic                     IFID_STALL_OUT,
  output logic                     IFID_FLUSH_OUT,
  output logic                     IDEXE_STALL_OUT,
  output logic                     IDEXE_FLUSH_OUT,
  output logic                     EXEMEM_STALL_OUT,
  output logic                     MEMWB_FLUSH_OUT,
  output logic                     MemTimeout_OUT,
  output logic [1:0]               o_dbg_state,
  output logic [TIMEOUT_WIDTH-1:0] o_dbg_wait_count
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0]              StallCycles_OUT,
  output logic [31:0]              FlushCount_OUT
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] LP_LAST_WAIT = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_ONE       = TIMEOUT_WIDTH'(1);

  state_t                   r_state;
  logic [TIMEOUT_WIDTH-1:0] r_wait_count;

  logic w_freeze;
  logic w_load_use;

  assign w_freeze = ((r_state == ST_RUN) && MemRequest_IN && !MemReady_IN) ||
                    ((r_state == ST_MEM_WAIT) && !MemReady_IN) ||
                    (r_state == ST_TIMEOUT);

  assign w_load_use = IDEXE_MemRead_IN && (IDEXE_WriteRegister_IN != 5'd0) &&
                      ((ID_UsesRS_IN && (ID_RegisterRS_IN == IDEXE_WriteRegister_IN)) ||
                       (ID_UsesRT_IN && (ID_RegisterRT_IN == IDEXE_WriteRegister_IN)));

  // Priority FREEZE > load-use > branch; a masked branch re-resolves once the pipe moves again.
  always_comb begin
    PC_STALL_OUT     = 1'b0;
    IFID_STALL_OUT   = 1'b0;
    IFID_FLUSH_OUT   = 1'b0;
    IDEXE_STALL_OUT  = 1'b0;
    IDEXE_FLUSH_OUT  = 1'b0;
    EXEMEM_STALL_OUT = 1'b0;
    MEMWB_FLUSH_OUT  = 1'b0;
    MemTimeout_OUT   = 1'b0;
    if (!RESET) begin
      MemTimeout_OUT = (r_state == ST_TIMEOUT);
      if (w_freeze) begin
        PC_STALL_OUT     = 1'b1;
        IFID_STALL_OUT   = 1'b1;
        IDEXE_STALL_OUT  = 1'b1;
        EXEMEM_STALL_OUT = 1'b1;
        MEMWB_FLUSH_OUT  = 1'b1;
      end else if (w_load_use) begin
        PC_STALL_OUT    = 1'b1;
        IFID_STALL_OUT  = 1'b1;
        IDEXE_FLUSH_OUT = 1'b1;
      end else if (BranchTaken_IN) begin
        IFID_FLUSH_OUT = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= ST_RUN;
      r_wait_count <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (MemRequest_IN && !MemReady_IN) begin
            r_state      <= ST_MEM_WAIT;
            r_wait_count <= LP_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (MemReady_IN) begin
            r_state      <= ST_RUN;
            r_wait_count <= '0;
          end else if (r_wait_count == LP_LAST_WAIT) begin
            r_state <= ST_TIMEOUT;
          end else begin
            r_wait_count <= r_wait_count + LP_ONE;
          end
        end
        ST_TIMEOUT: r_state <= ST_TIMEOUT;
        default: begin
          r_state      <= ST_RUN;
          r_wait_count <= '0;
        end
      endcase
    end
  end

  assign o_dbg_state      = r_state;
  assign o_dbg_wait_count = r_wait_count;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (PC_STALL_OUT && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if ((IFID_FLUSH_OUT || IDEXE_FLUSH_OUT) && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign StallCycles_OUT = r_stall_cycles;
  assign FlushCount_OUT  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed + randomized bench for hazard_sequencer against a cycle-count reference model.
module tb_hazard_sequencer;

  localparam int MEM_TIMEOUT   = 4;
  localparam int TIMEOUT_WIDTH = 8;

  logic       clk;
  logic       rst;
  logic [4:0] rs, rt, wr;
  logic       urs, urt, mrd, br, req, rdy;

  logic pc_s, ifid_s, ifid_f, idexe_s, idexe_f, exemem_s, memwb_f, m_timeout;
  logic [1:0]               dbg_state;
  logic [TIMEOUT_WIDTH-1:0] dbg_wait;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMEOUT_WIDTH(TIMEOUT_WIDTH)) dut (
    .CLOCK                  (clk),
    .RESET                  (rst),
    .ID_RegisterRS_IN       (rs),
    .ID_RegisterRT_IN       (rt),
    .ID_UsesRS_IN           (urs),
    .ID_UsesRT_IN           (urt),
    .IDEXE_MemRead_IN       (mrd),
    .IDEXE_WriteRegister_IN (wr),
    .BranchTaken_IN         (br),
    .MemRequest_IN          (req),
    .MemReady_IN            (rdy),
    .PC_STALL_OUT           (pc_s),
    .IFID_STALL_OUT         (ifid_s),
    .IFID_FLUSH_OUT         (ifid_f),
    .IDEXE_STALL_OUT        (idexe_s),
    .IDEXE_FLUSH_OUT        (idexe_f),
    .EXEMEM_STALL_OUT       (exemem_s),
    .MEMWB_FLUSH_OUT        (memwb_f),
    .MemTimeout_OUT         (m_timeout),
    .o_dbg_state            (dbg_state),
    .o_dbg_wait_count       (dbg_wait)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .StallCycles_OUT        (stall_cycles),
    .FlushCount_OUT         (flush_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_wait;   // consecutive not-ready cycles in the open memory episode
  bit m_to;
  int m_sc, m_fc;
  int total, bad;
  logic [7:0] exp_q[$];

  // Bit order: pc_s, ifid_s, ifid_f, idexe_s, idexe_f, exemem_s, memwb_f, timeout
  function automatic logic [7:0] model_out();
    logic       frz, lu;
    logic [7:0] o;
    o = 8'h00;
    if (rst) return o;
    frz = m_to || ((m_wait > 0) ? !rdy : (req && !rdy));
    lu  = mrd && (wr != 5'd0) && ((urs && rs == wr) || (urt && rt == wr));
    if (frz)     o = 8'b1101_0110;
    else if (lu) o = 8'b1100_1000;
    else if (br) o = 8'b0010_0000;
    o[0] = m_to;
    return o;
  endfunction

  task automatic model_update();
    logic [7:0] o;
    if (rst) begin
      m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      o = model_out();
      if (o[7]) m_sc++;
      if (o[5] || o[3]) m_fc++;
      if (!m_to) begin
        if ((m_wait > 0 || req) && !rdy) begin
          m_wait++;
          if (m_wait == MEM_TIMEOUT) m_to = 1;
        end else begin
          m_wait = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rs = 5'd0; rt = 5'd0; wr = 5'd0;
    urs = 0; urt = 0; mrd = 0; br = 0; req = 0; rdy = 0;
  endtask

  task automatic set_lu(input logic [4:0] r_s, input logic [4:0] r_t, input logic [4:0] w,
                        input logic u_s, input logic u_t);
    rs = r_s; rt = r_t; wr = w; urs = u_s; urt = u_t; mrd = 1'b1;
  endtask

  // Called at a negedge with inputs already driven: check, then advance one clock.
  task automatic cycle(input string tag);
    logic [7:0] obs, exp;
    exp_q.push_back(model_out());
    #1;
    obs = {pc_s, ifid_s, ifid_f, idexe_s, idexe_f, exemem_s, memwb_f, m_timeout};
    exp = exp_q.pop_front();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s outputs obs=%b exp=%b", tag, obs, exp);
    end
    if (!m_to) begin
      total++;
      assert (dbg_wait === TIMEOUT_WIDTH'(m_wait)) else begin
        bad++;
        $error("FAIL %s wait_count obs=%0d exp=%0d", tag, dbg_wait, m_wait);
      end
    end
`ifdef HAZARD_PERF_COUNTERS_EN
    total++;
    assert (stall_cycles === 32'(m_sc) && flush_count === 32'(m_fc)) else begin
      bad++;
      $error("FAIL %s perf obs=%0d/%0d exp=%0d/%0d", tag, stall_cycles, flush_count, m_sc, m_fc);
    end
`endif
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    total = 0; bad = 0;
    m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    // Reset forces outputs low even with a pending hazard and memory stall
    req = 1; rdy = 0; br = 1; set_lu(5'd5, 5'd0, 5'd5, 1, 0);
    cycle("reset_forced");
    cycle("reset_forced2");
    rst = 1'b0; set_idle();
    cycle("idle_after_reset");

    set_lu(5'd5, 5'd0, 5'd5, 1, 0);          cycle("lu_rs");
    set_idle(); urs = 1; rs = 5'd5;          cycle("lu_bubble_cleared");
    set_lu(5'd0, 5'd0, 5'd0, 1, 1);          cycle("lu_wr0_none");
    set_lu(5'd3, 5'd9, 5'd9, 1, 1);          cycle("lu_rt");
    set_lu(5'd9, 5'd3, 5'd9, 0, 1);          cycle("lu_unused_rs");
    set_idle(); br = 1;                      cycle("branch_alone");
    set_lu(5'd7, 5'd0, 5'd7, 1, 0); br = 1;  cycle("branch_plus_lu");
    set_idle(); br = 1;                      cycle("branch_reresolve");

    // Three not-ready cycles, branch and LU masked while frozen
    set_idle(); req = 1; rdy = 0; br = 1;    cycle("memwait_1");
    set_lu(5'd2, 5'd0, 5'd2, 1, 0); req = 0; cycle("memwait_2_lu_masked");
    set_idle();                              cycle("memwait_3");
    rdy = 1;                                 cycle("memwait_release");
    set_idle(); rdy = 0;                     cycle("ready_ignored_no_req");
    req = 1; rdy = 1;                        cycle("req_ready_same_cycle");

    // Timeout: exactly MEM_TIMEOUT not-ready cycles, then absorbing
    set_idle(); req = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) cycle("timeout_wait");
    rdy = 1; br = 1;                         cycle("timeout_sticky1");
    req = 0;                                 cycle("timeout_sticky2");
    rst = 1;                                 cycle("timeout_reset");
    rst = 0; set_idle();                     cycle("after_timeout_reset");

    // Reset during the second MEM_WAIT cycle
    req = 1; rdy = 0;                        cycle("midwait_enter");
    req = 0;                                 cycle("midwait_2");
    rst = 1;                                 cycle("midwait_reset");
    rst = 0;                                 cycle("midwait_run");

`ifdef HAZARD_PERF_COUNTERS_EN
    rst = 1; set_idle();                     cycle("perf_reset");
    rst = 0;
    set_lu(5'd4, 5'd0, 5'd4, 1, 0);          cycle("perf_lu1");
    set_idle();                              cycle("perf_gap");
    set_lu(5'd0, 5'd6, 5'd6, 0, 1);          cycle("perf_lu2");
    set_idle(); req = 1;                     cycle("perf_wait1");
    req = 0;                                 cycle("perf_wait2");
    cycle("perf_wait3");
    rdy = 1;                                 cycle("perf_release");
    set_idle();
    #1;
    total++;
    assert (stall_cycles === 32'd5 && flush_count === 32'd2) else begin
      bad++;
      $error("FAIL perf_directed obs=%0d/%0d exp=5/2", stall_cycles, flush_count);
    end
    @(negedge clk);
`endif

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      wr  = 5'($urandom_range(0, 3));
      urs = 1'($urandom_range(0, 1));
      urt = 1'($urandom_range(0, 1));
      mrd = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 3) == 0);
      req = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
